// File: rtl/painterengine_gpu_axi_reader.sv
// DMA read engine: splits an address/length job into 4 KB-safe AXI4 INCR read bursts
// and streams returned words to the requester under a valid/next handshake.
module painterengine_gpu_axi_reader #(
   parameter int unsigned PARAM_MAX_BURST = 16
) (
   input  logic        i_wire_clock,
   input  logic        i_wire_resetn,
   input  logic        i_wire_reader_resetn,
   input  logic [31:0] i_wire_reader_address,
   input  logic [31:0] i_wire_reader_length,
   output logic        o_wire_reader_done,
   output logic        o_wire_reader_error,
   output logic [31:0] o_wire_reader_data,
   output logic        o_wire_reader_data_valid,
   input  logic        i_wire_reader_data_next,
   output logic [31:0] o_wire_m_axi_araddr,
   output logic [7:0]  o_wire_m_axi_arlen,
   output logic [2:0]  o_wire_m_axi_arsize,
   output logic [1:0]  o_wire_m_axi_arburst,
   output logic        o_wire_m_axi_arvalid,
   input  logic        i_wire_m_axi_arready,
   input  logic [31:0] i_wire_m_axi_rdata,
   input  logic [1:0]  i_wire_m_axi_rresp,
   input  logic        i_wire_m_axi_rlast,
   input  logic        i_wire_m_axi_rvalid,
   output logic        o_wire_m_axi_rready
);

   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned BEAT_W     = 9;
   localparam int unsigned PAGE_W     = 13;
   localparam int unsigned PAGE_WDS_W = 11;

   typedef enum logic [2:0] {
      S_IDLE, S_CALC, S_ADDR, S_DATA, S_DRAIN, S_DONE, S_ERROR
   } state_t;

   state_t               state, state_next;
   logic [ADDR_W-1:0]    reg_address;
   logic [ADDR_W-1:0]    reg_remaining;
   logic [BEAT_W-1:0]    reg_beats;
   logic [BEAT_W-1:0]    reg_beat_count;
   logic                 reg_error_flag;
   logic                 reg_abort;

   logic [PAGE_W-1:0]     page_bytes;
   logic [PAGE_WDS_W-1:0] page_words;
   logic [ADDR_W-1:0]     burst_words;

   logic latch_job, load_beats, clear_count, take_beat, advance, set_err;
   logic beat, last_beat, resp_err;
   logic rready_c, data_valid_c;

   // Burst size: bounded by words left, max burst and words to the next 4 KB page
   always_comb begin
      page_bytes  = 13'd4096 - {1'b0, reg_address[11:0]};
      page_words  = PAGE_WDS_W'(page_bytes >> 2);
      burst_words = reg_remaining;
      if (burst_words > 32'(PARAM_MAX_BURST)) burst_words = 32'(PARAM_MAX_BURST);
      if (burst_words > 32'(page_words))      burst_words = 32'(page_words);
   end

   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) state <= S_IDLE;
      else                state <= state_next;
   end

   always_comb begin
      state_next   = state;
      rready_c     = 1'b0;
      data_valid_c = 1'b0;
      latch_job    = 1'b0;
      load_beats   = 1'b0;
      clear_count  = 1'b0;
      take_beat    = 1'b0;
      advance      = 1'b0;
      set_err      = 1'b0;
      beat         = 1'b0;
      last_beat    = (reg_beat_count + 9'd1) == reg_beats;
      resp_err     = i_wire_m_axi_rresp != 2'b00;
      unique case (state)
         S_IDLE: begin
            if (i_wire_reader_resetn) begin
               latch_job = 1'b1;
               if (i_wire_reader_length == 32'd0)            state_next = S_DONE;
               else if (i_wire_reader_address[1:0] != 2'b00) state_next = S_ERROR;
               else                                          state_next = S_CALC;
            end
         end
         S_CALC: begin
            if (!i_wire_reader_resetn) state_next = S_IDLE;
            else begin
               load_beats = 1'b1;
               state_next = S_ADDR;
            end
         end
         S_ADDR: begin
            // An issued AR must complete; an abort seen meanwhile drains the burst
            if (i_wire_m_axi_arready) begin
               clear_count = 1'b1;
               state_next  = (reg_abort || !i_wire_reader_resetn) ? S_DRAIN : S_DATA;
            end
         end
         S_DATA: begin
            rready_c     = i_wire_reader_data_next;
            beat         = i_wire_m_axi_rvalid & i_wire_reader_data_next;
            data_valid_c = beat & ~resp_err;
            if (beat) begin
               take_beat = 1'b1;
               if (!i_wire_reader_resetn) begin
                  state_next = i_wire_m_axi_rlast ? S_IDLE : S_DRAIN;
               end else if (resp_err || (i_wire_m_axi_rlast != last_beat)) begin
                  set_err    = 1'b1;
                  state_next = i_wire_m_axi_rlast ? S_ERROR : S_DRAIN;
               end else if (last_beat) begin
                  advance    = 1'b1;
                  state_next = (reg_remaining == 32'd1) ? S_DONE : S_CALC;
               end
            end else if (!i_wire_reader_resetn) begin
               state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            rready_c = 1'b1;
            if (i_wire_m_axi_rvalid && i_wire_m_axi_rlast)
               state_next = reg_error_flag ? S_ERROR : S_IDLE;
         end
         S_DONE, S_ERROR: begin
            if (!i_wire_reader_resetn) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Job datapath
   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         reg_address    <= '0;
         reg_remaining  <= '0;
         reg_beats      <= '0;
         reg_beat_count <= '0;
         reg_error_flag <= 1'b0;
         reg_abort      <= 1'b0;
      end else begin
         if (latch_job) begin
            reg_address   <= i_wire_reader_address;
            reg_remaining <= i_wire_reader_length;
         end
         if (load_beats)  reg_beats      <= BEAT_W'(burst_words);
         if (clear_count) reg_beat_count <= '0;
         if (take_beat) begin
            reg_beat_count <= reg_beat_count + 9'd1;
            reg_remaining  <= reg_remaining - 32'd1;
         end
         if (advance) reg_address <= reg_address + 32'({reg_beats, 2'b00});
         if (state_next == S_IDLE) reg_error_flag <= 1'b0;
         else if (set_err)         reg_error_flag <= 1'b1;
         if (state == S_ADDR) begin
            if (!i_wire_reader_resetn) reg_abort <= 1'b1;
         end else begin
            reg_abort <= 1'b0;
         end
      end
   end

   assign o_wire_m_axi_arvalid     = (state == S_ADDR);
   assign o_wire_m_axi_araddr      = o_wire_m_axi_arvalid ? reg_address : '0;
   assign o_wire_m_axi_arlen       = o_wire_m_axi_arvalid ? 8'(reg_beats - 9'd1) : '0;
   assign o_wire_m_axi_arsize      = 3'b010;
   assign o_wire_m_axi_arburst     = 2'b01;
   assign o_wire_m_axi_rready      = rready_c;
   assign o_wire_reader_data_valid = data_valid_c;
   assign o_wire_reader_data       = data_valid_c ? i_wire_m_axi_rdata : '0;
   assign o_wire_reader_done       = (state == S_DONE);
   assign o_wire_reader_error      = (state == S_ERROR);

endmodule

// File: doc/painterengine_gpu_axi_reader.md
# painterengine_gpu_axi_reader

DMA read engine: the responder end of the GPU display reader interface. It accepts an address/length job from a requester such as the display controller and fetches the words over an AXI4 read-only master port. It splits each job into INCR bursts that never cross a 4 KB boundary. Words are streamed to the requester's FIFO under a valid/next handshake, and the block reports done or error.

## Interface
Parameters:
- PARAM_MAX_BURST, 16, maximum beats per AXI burst (1..256)

Ports:
- i_wire_clock  in  1  system clock
- i_wire_resetn  in  1  asynchronous, active-low reset
- i_wire_reader_resetn  in  1  soft job enable, sampled synchronously; low = abort/idle, high = run job
- i_wire_reader_address  in  32  job byte address, must be 4-byte aligned
- i_wire_reader_length  in  32  job length in 32-bit words
- o_wire_reader_done  out  1  job completed without error (level)
- o_wire_reader_error  out  1  job failed (level)
- o_wire_reader_data  out  32  read word (= m_axi_rdata)
- o_wire_reader_data_valid  out  1  word transferred this cycle
- i_wire_reader_data_next  in  1  requester can accept a word
- o_wire_m_axi_araddr  out  32;  o_wire_m_axi_arlen  out  8;  o_wire_m_axi_arsize  out  3 (constant 3'b010);  o_wire_m_axi_arburst  out  2 (constant 2'b01)
- o_wire_m_axi_arvalid  out  1;  i_wire_m_axi_arready  in  1
- i_wire_m_axi_rdata  in  32;  i_wire_m_axi_rresp  in  2;  i_wire_m_axi_rlast  in  1;  i_wire_m_axi_rvalid  in  1;  o_wire_m_axi_rready  out  1

## Operation
- **State register.** The states are IDLE, CALC, ADDR, DATA, DRAIN, DONE and ERROR.
- **Job registers.** reg_address and reg_remaining are 32-bit. reg_beats is 9-bit. reg_beat_count counts beats in the current burst.
- **IDLE**
  - On reader_resetn=1, latch address and length.
  - If length==0, go to DONE.
  - If address[1:0]!=0, go to ERROR.
  - Otherwise go to CALC.
- **CALC**
  - reg_beats = min(reg_remaining, PARAM_MAX_BURST, (4096 - reg_address[11:0])>>2).
  - Go to ADDR.
- **ADDR**
  - Drive arvalid=1, araddr=reg_address, arlen=reg_beats-1.
  - On arready, go to DATA with beat count cleared.
- **DATA**
  - rready = data_next.
  - data_valid = rvalid & data_next. Every asserted data_valid is a consumed word; data is never presented without the requester accepting it.
  - On each beat: increment the beat count and decrement reg_remaining.
  - On rresp!=2'b00 on any beat: set the error flag and suppress data_valid for that beat and all later beats. If this is not the last beat, go to DRAIN; on the last beat, go to ERROR.
  - rlast must arrive exactly on beat reg_beats. If it arrives early, or is absent on the final beat, that is an error; drain until rlast, then go to ERROR.
  - On the last beat without error:
    - reg_address += reg_beats*4.
    - Go to DONE if reg_remaining reaches 0, else to CALC.
- **DRAIN**
  - rready=1 and data_valid=0 until rlast & rvalid.
  - Then go to ERROR if the error flag is set, else to IDLE (abort case).
- **DONE / ERROR**
  - Hold done=1 or error=1, as appropriate.
  - Issue no AXI traffic.
  - When reader_resetn=0, go to IDLE.
- **Abort.** reader_resetn=0 in any state:
  - From CALC or IDLE: go to IDLE.
  - From ADDR: keep arvalid asserted until arready (AXI rule), then go to DRAIN.
  - From DATA: go to DRAIN.
  - data_valid=0 from the cycle after reader_resetn is sampled low.
- **Error flag.** Cleared on entry to IDLE.

## Timing
- **Reset values.** Every output is 0 under i_wire_resetn=0, except the constant arsize=3'b010 and arburst=2'b01. The state returns to IDLE.
- **Start latency.**
  - reader_resetn rises at cycle 0.
  - CALC is entered at cycle 1.
  - arvalid goes high at cycle 2.
- **Pass-through signals.** data_valid and rready are combinational from rvalid/data_next, with zero latency.
- **Burst-to-burst gap.** After the last beat, CALC follows in 1 cycle and the next arvalid 1 cycle after that. One AR is outstanding at a time.
- **Completion.** done/error rise 1 cycle after the final beat or the error decision, and fall 1 cycle after reader_resetn is sampled low.
- **Simultaneous events.**
  - reader_resetn low on the same cycle as the final beat: abort takes priority; done is never asserted.
  - rresp error on the beat that also carries rlast: go directly to ERROR.
- **Arithmetic widths.**
  - The 4 KB term is computed in 13 bits.
  - reg_remaining never underflows, because reg_beats <= reg_remaining.

## Test plan
- addr 0x1000_0000, len 64, MAX_BURST 16, arready/rvalid/next tied high -> 4 ARs with arlen=15 at 0x1000_0000/040/080/0C0; 64 data_valid; done=1 one cycle after the 4th rlast.
- addr 0x0000_0FF0, len 8 -> AR arlen=3 @0xFF0, then arlen=3 @0x1000; 8 words in order; done.
- len 64, data_next toggling with a 1-of-3 pattern and random rvalid gaps -> rready tracks next; exactly 64 data_valid pulses with data matching the memory model; done.
- len 32, rresp=SLVERR on beat 2 of burst 1 -> data_valid low from that beat; rready held until rlast; no further AR; error=1, done=0; error clears 1 cycle after reader_resetn=0.
- len 64, reader_resetn dropped after 5 beats -> no data_valid afterwards; burst drained to rlast; no new AR; IDLE. A new job (len 16) then completes normally.
- len 0 -> done=1 at cycle 1 with no AR. addr 0x1000_0002 -> error=1 with no AR.
